// File: rtl/modulo_pkg.sv
// Shared constants for the modulo datapath: ALU command encoding (also used by
// the ALU itself) and the sequencer state encoding.
package modulo_pkg;

  localparam logic [2:0] ALU_COMPARE = 3'd0;
  localparam logic [2:0] ALU_DIFF    = 3'd1;
  localparam logic [2:0] ALU_IDLE    = 3'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_SUB  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/modulo_ctrl.sv
// Sequencer that computes op_a mod op_b (and the quotient) by alternating
// compare and subtract commands on the shared modulo ALU.
module modulo_ctrl
  import modulo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic [2:0]       alu_mode_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_res_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] quot_reg;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic             err_q;

  // NOTE: every register here uses non-blocking assignment so all of them
  // see the pre-edge values; reset is synchronous, so it lives inside the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      quot_reg <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            a_reg    <= op_a_i;
            b_reg    <= op_b_i;
            quot_reg <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            if (op_b_i == '0) begin
              err_q <= 1'b1;
              state <= ST_DONE;
            end else begin
              err_q <= 1'b0;
              state <= ST_CMP;
            end
          end
        end
        // ALU returns zero when a_reg >= b_reg, so equality still subtracts
        ST_CMP: begin
          if (alu_res_i == '0) begin
            state <= ST_SUB;
          end else begin
            rem_q  <= a_reg;
            quot_q <= quot_reg;
            state  <= ST_DONE;
          end
        end
        ST_SUB: begin
          a_reg    <= alu_res_i;
          quot_reg <= quot_reg + WIDTH'(1);
          state    <= ST_CMP;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned.
  always_comb begin
    alu_mode_o = ALU_IDLE;
    alu_a_o    = '0;
    alu_b_o    = '0;
    case (state)
      ST_CMP: begin
        alu_mode_o = ALU_COMPARE;
        alu_a_o    = a_reg;
        alu_b_o    = b_reg;
      end
      ST_SUB: begin
        alu_mode_o = ALU_DIFF;
        alu_a_o    = a_reg;
        alu_b_o    = b_reg;
      end
      default: ;
    endcase
  end

  assign busy_o = (state == ST_CMP) || (state == ST_SUB);
  assign done_o = (state == ST_DONE);
  assign err_o  = err_q;
  assign rem_o  = rem_q;
  assign quot_o = quot_q;

endmodule

// File: tb/tb_modulo_ctrl.sv
// Scoreboard bench for modulo_ctrl: a behavioural ALU closes the loop, the
// driver queues hand-computed results and a done_o monitor compares them.
module tb_modulo_ctrl;
  import modulo_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [2:0]  alu_mode;
  logic [15:0] alu_a, alu_b, alu_res;
  logic        busy_o, done_o, err_o;
  logic [15:0] rem_o, quot_o;

  modulo_ctrl #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .alu_mode_o (alu_mode),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_res_i  (alu_res),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .rem_o      (rem_o),
    .quot_o     (quot_o)
  );

  always #5 clk = ~clk;

  // Reference ALU: compare yields 0 when a >= b
  always_comb begin
    alu_res = '0;
    case (alu_mode)
      ALU_COMPARE: alu_res = (alu_a >= alu_b) ? 16'd0 : 16'd1;
      ALU_DIFF:    alu_res = alu_a - alu_b;
      default:     alu_res = '0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] rem;
    logic [15:0] quot;
    logic        err;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && done_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL done_without_request: done_o high at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("rem",        rem_o,  e.rem);
        check("quot",       quot_o, e.quot);
        check("err",        err_o,  e.err);
        check("done_cycle", cyc,    e.done_cyc);
        check("busy_at_done", busy_o, 0);
      end
      done_seen++;
    end
  end

  // poke > 0 pulses start (with unrelated operands) poke cycles after the
  // accepted start; the sequencer must ignore it.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic [15:0] eq,
                        input logic ee, input int lat, input int poke);
    int   c, seen0, busy_cnt, budget;
    exp_t e;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    c     = cyc;
    e.rem = er; e.quot = eq; e.err = ee; e.done_cyc = c + lat;
    exp_q.push_back(e);
    seen0    = done_seen;
    busy_cnt = 0;
    budget   = 0;
    @(negedge clk);
    #1;
    forever begin
      start = (poke > 0) && (cyc - c == poke);
      if (start) begin
        op_a = 16'd9;
        op_b = 16'd2;
      end
      if (done_seen != seen0) break;
      if (budget >= lat + 20) break;
      if (busy_o) busy_cnt++;
      budget++;
      @(negedge clk);
      #1;
    end
    if (done_seen == seen0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: no done_o for %0d mod %0d within %0d cycles", a, b, lat + 20);
    end else begin
      check("busy_cycles", busy_cnt, lat - 1);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    check("idle_busy_after_done", busy_o, 0);
    check("idle_mode_after_done", alu_mode, ALU_IDLE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mode",  alu_mode, ALU_IDLE);
    check("rst_alu_a", alu_a,    0);
    check("rst_alu_b", alu_b,    0);
    check("rst_busy",  busy_o,   0);
    check("rst_done",  done_o,   0);
    check("rst_err",   err_o,    0);
    check("rst_rem",   rem_o,    0);
    check("rst_quot",  quot_o,   0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_op(16'd17, 16'd5, 16'd2, 16'd3, 1'b0, 8, 3);
    run_op(16'd3,  16'd7, 16'd3, 16'd0, 1'b0, 2, 2);
    run_op(16'd20, 16'd5, 16'd0, 16'd4, 1'b0, 10, 0);
    run_op(16'd10, 16'd0, 16'd0, 16'd0, 1'b1, 1, 0);
    repeat (3) @(negedge clk);
    #1;
    check("err_held", err_o, 1);
    check("err_rem_held", rem_o, 0);
    run_op(16'd5,      16'd5,     16'd0,   16'd1,    1'b0, 4, 0);
    run_op(16'd0,      16'd9,     16'd0,   16'd0,    1'b0, 2, 0);
    run_op(16'hFFFF,   16'h0100,  16'h00FF, 16'h00FF, 1'b0, 512, 0);
    run_op(16'd9999,   16'd1,     16'd0,   16'd9999, 1'b0, 20000, 0);

    // Abort 1000 mod 3 during its first subtract
    @(negedge clk);
    op_a  = 16'd1000;
    op_b  = 16'd3;
    start = 1'b1;
    c     = cyc;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("abort_cmp_mode", alu_mode, ALU_COMPARE);
    @(negedge clk);
    #1;
    check("abort_sub_mode", alu_mode, ALU_DIFF);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("abort_mode",  alu_mode, ALU_IDLE);
    check("abort_alu_a", alu_a,    0);
    check("abort_alu_b", alu_b,    0);
    check("abort_busy",  busy_o,   0);
    check("abort_done",  done_o,   0);
    check("abort_rem",   rem_o,    0);
    check("abort_quot",  quot_o,   0);
    check("abort_err",   err_o,    0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    run_op(16'd7, 16'd2, 16'd1, 16'd3, 1'b0, 8, 0);

    repeat (5) @(negedge clk);
    check("pending_results", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
